// File: rtl/frame_stream_tx_pkg.sv
// Shared types and sizing for frame_stream_tx: widths, read FSM encoding, RAM write payload.
package frame_stream_tx_pkg;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH_W    = 10;
    localparam int unsigned BYTE_SHIFT = 2;
    localparam int unsigned IDX_W      = ADDR_W - BYTE_SHIFT;
    localparam int unsigned LEN_W      = DEPTH_W + 1;
    localparam int unsigned RAM_AW     = DEPTH_W + 1;
    localparam int unsigned RAM_WORDS  = 1 << RAM_AW;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2,
        RD_CSUM   = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_wr_t;

    // Frame length after writing word idx: grows to idx+1, never shrinks.
    function automatic logic [LEN_W-1:0] grow_len(input logic [LEN_W-1:0] cur,
                                                   input logic [DEPTH_W-1:0] idx);
        logic [LEN_W-1:0] nxt;
        nxt = LEN_W'(idx) + LEN_W'(1);
        return (nxt > cur) ? nxt : cur;
    endfunction

endpackage

// File: rtl/frame_stream_tx_if.sv
// Word-write and AXI4-Stream signals of frame_stream_tx; master = the streaming block.
interface frame_stream_tx_if;
    import frame_stream_tx_pkg::*;

    logic              start;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] address;
    logic              trigger;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport master (
        input  start, data, address, trigger, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output start, data, address, trigger, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame RAM, two banks selected by the address MSB; 1-cycle registered read.
module frame_bank_ram
    import frame_stream_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  ram_wr_t           wr_i,
    input  logic              re_i,
    input  logic [RAM_AW-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:RAM_WORDS-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_i.addr] <= wr_i.data;
        end
    end

    // Read register holds its value while re_i is low, which keeps stalled beats stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_stream_tx.sv
// Ping-pong frame buffer: captures word writes, streams each triggered frame on AXI4-Stream.
// Define FRAME_CHECKSUM_EN to append a mod-2^32 sum beat after the last word of each frame.
module frame_stream_tx
    import frame_stream_tx_pkg::*;
(
    input  logic              aclk,
    input  logic              rst,
    frame_stream_tx_if.master bus,
    output logic              busy,
    output logic              frame_drop,
    output logic              oob_err
);

    logic              start_d_q, trig_d_q;
    logic              wr_bank_q;
    logic [LEN_W-1:0]  len_max_q;
    logic              oob_q, drop_q, busy_q;

    rd_state_e         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic              wr_stb_c, trig_stb_c, wr_in_range_c, wr_en_c, frame_go_c, hs_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [LEN_W-1:0]  len_upd_c;
    ram_wr_t           ram_wr_c;
    logic              ram_re_c;
    logic [RAM_AW-1:0] ram_raddr_c;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.address[BYTE_SHIFT-1:0];

    // Write-side decode; a write in the trigger cycle still counts toward the frame.
    always_comb begin
        wr_stb_c      = bus.start & ~start_d_q;
        trig_stb_c    = bus.trigger & ~trig_d_q;
        wr_idx_c      = bus.address[ADDR_W-1:BYTE_SHIFT];
        wr_in_range_c = (wr_idx_c[IDX_W-1:DEPTH_W] == '0);
        wr_en_c       = wr_stb_c & wr_in_range_c;
        len_upd_c     = wr_en_c ? grow_len(len_max_q, wr_idx_c[DEPTH_W-1:0]) : len_max_q;
        frame_go_c    = trig_stb_c & (len_upd_c != '0);
        ram_wr_c.addr = {wr_bank_q, wr_idx_c[DEPTH_W-1:0]};
        ram_wr_c.data = bus.data;
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            start_d_q <= 1'b0;
            trig_d_q  <= 1'b0;
            wr_bank_q <= 1'b0;
            len_max_q <= '0;
            oob_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            start_d_q <= bus.start;
            trig_d_q  <= bus.trigger;
            drop_q    <= frame_go_c & (state_q != RD_IDLE);
            if (wr_stb_c & ~wr_in_range_c) begin
                oob_q <= 1'b1;
            end
            if (frame_go_c) begin
                len_max_q <= '0;
                if (state_q == RD_IDLE) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end else begin
                len_max_q <= len_upd_c;
            end
        end
    end

    // Read FSM: the RAM read register is the output stage; a new word is read only on handshake.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_len_d    = rd_len_q;
        rd_ptr_d    = rd_ptr_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
`ifdef FRAME_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        ram_re_c    = 1'b0;
        ram_raddr_c = {rd_bank_q, rd_ptr_q[DEPTH_W-1:0]};
        hs_c        = tvalid_q & bus.m_axis_tready;

        unique case (state_q)
            RD_IDLE: begin
                if (frame_go_c) begin
                    state_d   = RD_FETCH;
                    rd_bank_d = wr_bank_q;
                    rd_len_d  = len_upd_c;
                end
            end
            RD_FETCH: begin
                ram_re_c    = 1'b1;
                ram_raddr_c = {rd_bank_q, DEPTH_W'(0)};
                rd_ptr_d    = LEN_W'(1);
                tvalid_d    = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                tlast_d     = 1'b0;
                sum_d       = '0;
`else
                tlast_d     = (rd_len_q == LEN_W'(1));
`endif
                state_d     = RD_STREAM;
            end
            RD_STREAM: begin
                if (hs_c) begin
`ifdef FRAME_CHECKSUM_EN
                    sum_d = sum_q + ram_rdata;
`endif
                    if (rd_ptr_q != rd_len_q) begin
                        ram_re_c = 1'b1;
                        rd_ptr_d = rd_ptr_q + LEN_W'(1);
`ifdef FRAME_CHECKSUM_EN
                        tlast_d  = 1'b0;
`else
                        tlast_d  = (rd_ptr_q == rd_len_q - LEN_W'(1));
`endif
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        state_d  = RD_CSUM;
                        tlast_d  = 1'b1;
`else
                        state_d  = RD_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
`endif
                    end
                end
            end
            RD_CSUM: begin
                if (hs_c) begin
                    state_d  = RD_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            state_q   <= RD_IDLE;
            rd_bank_q <= 1'b0;
            rd_len_q  <= '0;
            rd_ptr_q  <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_len_q  <= rd_len_d;
            rd_ptr_q  <= rd_ptr_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            busy_q    <= (state_d != RD_IDLE);
`ifdef FRAME_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    frame_bank_ram u_ram (
        .clk     (aclk),
        .rst_n   (rst),
        .we_i    (wr_en_c),
        .wr_i    (ram_wr_c),
        .re_i    (ram_re_c),
        .raddr_i (ram_raddr_c),
        .rdata_o (ram_rdata)
    );

`ifdef FRAME_CHECKSUM_EN
    assign bus.m_axis_tdata = (state_q == RD_CSUM) ? sum_q : ram_rdata;
`else
    assign bus.m_axis_tdata = ram_rdata;
`endif
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign busy              = busy_q;
    assign frame_drop        = drop_q;
    assign oob_err           = oob_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx: directed and random frames checked against a frame-level model.
// Honours FRAME_CHECKSUM_EN the same way as the design.
module tb_frame_stream_tx;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    logic busy, frame_drop, oob_err;

    frame_stream_tx_if bus ();

    frame_stream_tx dut (
        .aclk       (aclk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .frame_drop (frame_drop),
        .oob_err    (oob_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        bit          known;
        bit          last;
    } beat_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    int          in_flight = 0;
    int          drops_seen = 0;
    int          m_len    = 0;
    bit          m_bank   = 1'b0;
    bit          drop_pend = 1'b0;
    bit          exp_oob  = 1'b0;
    logic [31:0] mmem   [2][1024];
    bit          mknown [2][1024];
    beat_t       exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_len = 0; m_bank = 1'b0; in_flight = 0; drop_pend = 1'b0; exp_oob = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_write(input logic [14:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a) / 4;
        if (idx >= 1024) begin
            exp_oob = 1'b1;
        end else begin
            mmem[m_bank][idx]   = d;
            mknown[m_bank][idx] = 1'b1;
            if (idx + 1 > m_len) m_len = idx + 1;
        end
    endtask

    // A frame is a snapshot of the write bank at trigger time, words 0..len-1.
    task automatic model_trigger();
        beat_t       b;
        logic [31:0] sum;
        bit          sum_known;
        if (m_len == 0) return;
        if (in_flight > 0) begin
            drop_pend = 1'b1;
            m_len = 0;
            return;
        end
        sum = 32'd0; sum_known = 1'b1;
        for (int i = 0; i < m_len; i++) begin
            b.d = mmem[m_bank][i];
            b.known = mknown[m_bank][i];
`ifdef FRAME_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == m_len - 1);
`endif
            exp_q.push_back(b);
            sum = sum + b.d;
            sum_known = sum_known & b.known;
        end
`ifdef FRAME_CHECKSUM_EN
        b.d = sum; b.known = sum_known; b.last = 1'b1;
        exp_q.push_back(b);
`endif
        in_flight++;
        m_bank = ~m_bank;
        m_len = 0;
    endtask

    task automatic take_beat(input logic [31:0] d, input logic l);
        beat_t b;
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("tlast", 32'(l), 32'(b.last));
            if (b.known) chk("tdata", d, b.d);
            if (b.last) in_flight--;
        end
    endtask

    // One clock: drive tready, log a handshake, advance, then check stalls and status flags.
    task automatic tick();
        logic        stall_p, l_p;
        logic [31:0] d_p;
        cyc++;
        case (rdy_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = cyc[0];
            2:       bus.m_axis_tready = 1'($urandom_range(0, 1));
            default: bus.m_axis_tready = 1'b0;
        endcase
        stall_p = bus.m_axis_tvalid & ~bus.m_axis_tready;
        d_p = bus.m_axis_tdata;
        l_p = bus.m_axis_tlast;
        if (bus.m_axis_tvalid && bus.m_axis_tready) take_beat(bus.m_axis_tdata, bus.m_axis_tlast);
        @(posedge aclk);
        #1;
        if (stall_p) begin
            chk("hold_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
            chk("hold_tdata", bus.m_axis_tdata, d_p);
            chk("hold_tlast", 32'(bus.m_axis_tlast), 32'(l_p));
        end
        chk("frame_drop", 32'(frame_drop), 32'(drop_pend));
        drop_pend = 1'b0;
        if (frame_drop) drops_seen++;
        chk("busy", 32'(busy), 32'(in_flight > 0));
        chk("oob_err", 32'(oob_err), 32'(exp_oob));
    endtask

    task automatic write_word(input logic [14:0] a, input logic [31:0] d, input int hold);
        bus.start = 1'b1; bus.address = a; bus.data = d;
        model_write(a, d);
        tick();
        for (int i = 1; i < hold; i++) begin
            bus.data = ~d ^ 32'(i);
            tick();
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic fire_trigger(input int hold);
        bus.trigger = 1'b1;
        model_trigger();
        for (int i = 0; i < hold; i++) tick();
        bus.trigger = 1'b0;
        tick();
    endtask

    task automatic drain(input int mode, input int budget);
        int n;
        n = 0;
        rdy_mode = mode;
        while (in_flight > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(in_flight), 32'd0);
        chk("drain_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic write_frame1();
        write_word(15'h0000, 32'hC623_0121, 2);
        write_word(15'h0004, 32'h0001_0002, 1);
        write_word(15'h0010, 32'h0000_000A, 3);
        write_word(15'h0014, 32'h0000_000B, 1);
        write_word(15'h0018, 32'h0000_000C, 1);
    endtask

    initial begin
        int d0;
        logic [14:0] a;
        bus.start = 1'b0; bus.data = '0; bus.address = '0; bus.trigger = 1'b0;
        bus.m_axis_tready = 1'b0;
        model_reset();
        #3 rst = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("rst_tdata", bus.m_axis_tdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        rst = 1'b1;
        tick();

        // Frame with gaps, tready high: first beat two cycles after the trigger.
        write_frame1();
        rdy_mode = 0;
        bus.trigger = 1'b1;
        model_trigger();
        tick();
        chk("fetch_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        tick();
        chk("first_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        chk("first_tdata", bus.m_axis_tdata, 32'hC623_0121);
        bus.trigger = 1'b0;
        drain(0, 100);

        // Same frame under alternating tready.
        rdy_mode = 1;
        write_frame1();
        fire_trigger(2);
        drain(1, 200);

        // Ping-pong: frame B written into the other bank while A streams.
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) write_word(15'(4 * i), $urandom, 1);
        fire_trigger(1);
        for (int i = 0; i < 3; i++) write_word(15'(4 * i), $urandom, 1);
        drain(2, 200);
        fire_trigger(1);
        drain(0, 100);

        // Drop: second trigger while the first frame is stalled.
        rdy_mode = 3;
        d0 = drops_seen;
        write_word(15'h0000, 32'hAAAA_0000, 1);
        write_word(15'h0004, 32'hAAAA_0001, 1);
        fire_trigger(1);
        for (int i = 0; i < 3; i++) write_word(15'(4 * i), 32'hBBBB_0000 + 32'(i), 1);
        fire_trigger(2);
        chk("drop_count", 32'(drops_seen - d0), 32'd1);
        drain(0, 100);
        write_word(15'h0000, 32'hCCCC_0000, 1);
        write_word(15'h0004, 32'hCCCC_0001, 1);
        fire_trigger(1);
        drain(0, 100);

        // Out-of-range write, empty trigger, held start.
        write_word(15'h1000, 32'hDEAD_BEEF, 1);
        chk("oob_set", 32'(oob_err), 32'd1);
        d0 = drops_seen;
        fire_trigger(2);
        repeat (3) tick();
        chk("empty_trig_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("empty_trig_drop", 32'(drops_seen - d0), 32'd0);
        write_word(15'h0008, 32'h1234_5678, 4);
        fire_trigger(1);
        drain(0, 100);

        // Write and trigger rising in the same cycle: the write joins the frame.
        write_word(15'h0000, 32'h5555_0000, 1);
        write_word(15'h0004, 32'h5555_0001, 1);
        bus.start = 1'b1; bus.address = 15'h0008; bus.data = 32'h5555_0002;
        bus.trigger = 1'b1;
        model_write(15'h0008, 32'h5555_0002);
        model_trigger();
        tick();
        bus.start = 1'b0; bus.trigger = 1'b0;
        tick();
        drain(0, 100);

        // Frame 1,2,3 (checksum beat 6 when enabled).
        for (int i = 0; i < 3; i++) write_word(15'(4 * i), 32'(i + 1), 1);
        fire_trigger(1);
        drain(0, 100);

        // Random frames, random backpressure, triggers sometimes while busy.
        for (int f = 0; f < 16; f++) begin
            rdy_mode = $urandom_range(0, 2);
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                a = 15'(4 * $urandom_range(0, 11));
                if ($urandom_range(0, 9) == 0) a = 15'(32'h1000 + 4 * $urandom_range(0, 100));
                write_word(a, $urandom, $urandom_range(1, 3));
            end
            fire_trigger($urandom_range(1, 3));
            if ($urandom_range(0, 2) != 0) drain(rdy_mode, 400);
        end
        drain(0, 400);

        // Async reset mid-stream loses the frame at once.
        for (int i = 0; i < 4; i++) write_word(15'(4 * i), $urandom, 1);
        fire_trigger(1);
        rdy_mode = 3;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) write_word(15'(4 * i), 32'h7000_0000 + 32'(i), 1);
        fire_trigger(1);
        drain(2, 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
